// File: rtl/core_pkg.sv
// Shared types and constants for the fetch front end: next-PC select codes,
// fetch FSM states and the sequential PC increment.
`timescale 1ns/1ps
package core_pkg;

  typedef enum logic [1:0] {
    PCSRC_JR  = 2'b00,
    PCSRC_J   = 2'b01,
    PCSRC_BR  = 2'b10,
    PCSRC_SEQ = 2'b11
  } pcsrc_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    HOLD = 2'b10
  } fetch_state_t;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/next_pc_calc.sv
// Redirect target selection for JR, J/JAL and taken branches; all sums wrap mod 2^32.
`timescale 1ns/1ps
module next_pc_calc
  import core_pkg::*;
(
  input  logic [1:0]  pcsrc,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] jr_target,
  input  logic [25:0] j_index,
  input  logic [15:0] br_offset,
  output logic [31:0] target
);

  logic [31:0] seq_pc_s;

  assign seq_pc_s = redirect_pc + PC_INC;

  // Select the target; the sequential code never reaches the PC but still gets a defined value
  always_comb begin
    target = seq_pc_s;
    case (pcsrc_t'(pcsrc))
      PCSRC_JR: target = jr_target;
      PCSRC_J:  target = {seq_pc_s[31:28], j_index, 2'b00};
      PCSRC_BR: target = seq_pc_s + {{14{br_offset[15]}}, br_offset, 2'b00};
      default:  target = seq_pc_s;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: owns the PC, keeps one imem request in flight and buffers one
// extra response while decode stalls; taken redirects squash the wrong path.
`timescale 1ns/1ps
module pc_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PCSrcs,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] jr_target,
  input  logic [25:0] j_index,
  input  logic [15:0] br_offset,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  fetch_state_t state_r;
  logic [31:0]  pc_r;
  logic [31:0]  req_pc_r;
  logic         kill_r;
  logic [31:0]  hold_instr_r;
  logic [31:0]  hold_pc_r;
  logic         if_valid_r;
  logic [31:0]  if_instr_r;
  logic [31:0]  if_pc_r;
  logic [31:0]  if_pc_plus4_r;
  logic         redirect_taken_s;
  logic [31:0]  target_s;

  next_pc_calc u_next_pc_calc (
    .pcsrc       (PCSrcs),
    .redirect_pc (redirect_pc),
    .jr_target   (jr_target),
    .j_index     (j_index),
    .br_offset   (br_offset),
    .target      (target_s)
  );

  assign redirect_taken_s = redirect_valid && (PCSrcs != 2'b11);

  // Gating on reset keeps the request quiet while the async reset is held
  assign imem_req    = reset && (state_r == IDLE) && !redirect_taken_s;
  assign imem_addr   = pc_r;
  assign if_valid    = if_valid_r;
  assign if_instr    = if_instr_r;
  assign if_pc       = if_pc_r;
  assign if_pc_plus4 = if_pc_plus4_r;

  // Fetch FSM, kill flag, hold buffer and decode-facing output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      req_pc_r      <= 32'h0000_0000;
      kill_r        <= 1'b0;
      hold_instr_r  <= 32'h0000_0000;
      hold_pc_r     <= 32'h0000_0000;
      if_valid_r    <= 1'b0;
      if_instr_r    <= 32'h0000_0000;
      if_pc_r       <= 32'h0000_0000;
      if_pc_plus4_r <= 32'h0000_0000;
    end else if (redirect_taken_s) begin
      pc_r         <= target_s;
      if_valid_r   <= 1'b0;
      hold_instr_r <= 32'h0000_0000;
      hold_pc_r    <= 32'h0000_0000;
      case (state_r)
        WAIT: begin
          // A response landing with the redirect is dropped here; otherwise it is killed later
          if (imem_rvalid) begin
            state_r <= IDLE;
            kill_r  <= 1'b0;
          end else begin
            state_r <= WAIT;
            kill_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          kill_r  <= 1'b0;
        end
      endcase
    end else begin
      if (if_valid_r && !stall) begin
        if_valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (imem_gnt) begin
            req_pc_r <= pc_r;
            pc_r     <= pc_r + PC_INC;
            state_r  <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (kill_r) begin
              kill_r  <= 1'b0;
              state_r <= IDLE;
            end else if (!if_valid_r || !stall) begin
              if_valid_r    <= 1'b1;
              if_instr_r    <= imem_rdata;
              if_pc_r       <= req_pc_r;
              if_pc_plus4_r <= req_pc_r + PC_INC;
              state_r       <= IDLE;
            end else begin
              hold_instr_r <= imem_rdata;
              hold_pc_r    <= req_pc_r;
              state_r      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            if_valid_r    <= 1'b1;
            if_instr_r    <= hold_instr_r;
            if_pc_r       <= hold_pc_r;
            if_pc_plus4_r <= hold_pc_r + PC_INC;
            state_r       <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Randomised scoreboard bench for pc_fetch: a driver plays memory and branch
// stage and predicts the instruction stream; a monitor checks decode handshakes.
`timescale 1ns/1ps
module tb_pc_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int NCYC = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  PCSrcs;
  logic        redirect_valid;
  logic [31:0] redirect_pc, jr_target;
  logic [25:0] j_index;
  logic [15:0] br_offset;
  logic        stall;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, if_pc_plus4;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4;

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .PCSrcs(PCSrcs), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .jr_target(jr_target), .j_index(j_index),
    .br_offset(br_offset), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  // Free-running instance starting just below the wrap point
  pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .PCSrcs(2'b11), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .jr_target(32'h0), .j_index(26'h0),
    .br_offset(16'h0), .stall(1'b0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(1'b1), .imem_rvalid(1'b1), .imem_rdata(32'h0),
    .if_valid(w_valid), .if_instr(w_instr), .if_pc(w_pc), .if_pc_plus4(w_pc4)
  );

  typedef struct {
    int unsigned ep;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          delivered = 0;
  int unsigned epoch = 0;
  logic [31:0] model_fetch_pc = RST_PC;

  int          dir_cyc[4] = '{30, 45, 60, 75};
  logic [1:0]  dir_src[4] = '{2'b10, 2'b01, 2'b00, 2'b11};
  logic [31:0] dir_rpc[4] = '{32'h0000_0100, 32'h8000_0010, 32'h0000_0040, 32'h0000_0200};
  logic [31:0] dir_jr[4]  = '{32'h0, 32'h0, 32'h0000_1234, 32'h0000_9999};
  logic [25:0] dir_ji[4]  = '{26'h0, 26'h000_0040, 26'h0, 26'h0};
  logic [15:0] dir_off[4] = '{16'hFFFE, 16'h0, 16'h0, 16'h0};
  logic [31:0] dir_exp[4] = '{32'h0000_00FC, 32'h8000_0100, 32'h0000_1234, 32'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_target(input logic [1:0] src, input logic [31:0] rpc,
                                             input logic [31:0] jr, input logic [25:0] ji,
                                             input logic [15:0] off);
    logic [31:0] seq;
    int so;
    seq = rpc + 32'd4;
    so  = int'($signed(off));
    case (src)
      2'b00:   return jr;
      2'b01:   return (seq & 32'hF000_0000) | (32'(ji) * 32'd4);
      2'b10:   return seq + 32'(so * 4);
      default: return seq;
    endcase
  endfunction

  // Driver: memory responder, branch-stage stimulus, fetch-address prediction
  initial begin
    bit          pend = 1'b0;
    bit          stale = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = 32'h0;
    bit          redir_prev = 1'b0;
    logic [31:0] redir_tgt = 32'h0;
    int          rst_cnt = 2;
    int          rel_cyc = -1;
    exp_t        e;

    reset = 1'b0;
    PCSrcs = 2'b11; redirect_valid = 1'b0; redirect_pc = 32'h0; jr_target = 32'h0;
    j_index = 26'h0; br_offset = 16'h0; stall = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      int ph;
      int dly;
      int stall_pct;
      bit redir_now;
      bit do_rst;

      @(negedge clk);
      if (redir_prev) begin
        epoch++;
        model_fetch_pc = redir_tgt;
        redir_prev = 1'b0;
      end
      if (!reset) begin
        if (rst_cnt == 0) begin
          reset = 1'b1;
          if (rel_cyc < 0) rel_cyc = cyc;
        end else begin
          rst_cnt--;
        end
      end
      ph = (cyc < 20) ? 0 : ((cyc < 100) ? 1 : 2);

      imem_rvalid = 1'b0;
      imem_rdata  = $urandom();
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = pend_data;
          pend  = 1'b0;
          stale = 1'b0;
        end else begin
          pend_cnt--;
        end
      end else if (ph == 2 && $urandom_range(0, 19) == 0) begin
        imem_rvalid = 1'b1;
      end

      stall_pct = (ph == 2) ? ((((cyc / 250) % 2) != 0) ? 60 : 15) : 0;
      stall     = ($urandom_range(0, 99) < stall_pct);
      imem_gnt  = !pend && (ph < 2 || $urandom_range(0, 9) < 7);
      dly       = (ph == 0) ? 1 : ((ph == 1) ? 3 : $urandom_range(1, 4));
      do_rst    = (ph == 2) && reset && ((cyc % 300) == 150);

      redirect_valid = 1'b0;
      PCSrcs      = 2'($urandom_range(0, 3));
      redirect_pc = $urandom();
      jr_target   = $urandom();
      j_index     = 26'($urandom());
      br_offset   = 16'($urandom());
      redir_now   = 1'b0;
      if (reset && !do_rst) begin
        if (ph == 1) begin
          for (int i = 0; i < 4; i++) begin
            if (cyc == dir_cyc[i]) begin
              redirect_valid = 1'b1;
              PCSrcs = dir_src[i]; redirect_pc = dir_rpc[i]; jr_target = dir_jr[i];
              j_index = dir_ji[i]; br_offset = dir_off[i];
              redir_now = (dir_src[i] != 2'b11);
              redir_tgt = dir_exp[i];
            end
          end
        end else if (ph == 2 && $urandom_range(0, 99) < 8) begin
          redirect_valid = 1'b1;
          redir_now = (PCSrcs != 2'b11);
          redir_tgt = ref_target(PCSrcs, redirect_pc, jr_target, j_index, br_offset);
        end
      end

      if (do_rst) begin
        #2;
        reset = 1'b0;
        rst_cnt = 1;
        epoch++;
        model_fetch_pc = RST_PC;
        if (pend) stale = 1'b1;
        #1;
        chk("async_rst_if_valid", 32'(if_valid), 32'h0);
        chk("async_rst_if_pc", if_pc, 32'h0);
        chk("async_rst_if_instr", if_instr, 32'h0);
        chk("async_rst_if_pc_plus4", if_pc_plus4, 32'h0);
        chk("async_rst_req", 32'(imem_req), 32'h0);
      end else begin
        #3;
      end

      if (rel_cyc >= 0 && cyc == rel_cyc) begin
        chk("wrap_req", 32'(w_req), 32'h1);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      end
      if (rel_cyc >= 0 && cyc == rel_cyc + 2) begin
        chk("wrap_addr1", w_addr, 32'h0000_0000);
        chk("wrap_if_valid", 32'(w_valid), 32'h1);
        chk("wrap_if_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_if_pc_plus4", w_pc4, 32'h0000_0000);
        chk("wrap_if_instr", w_instr, 32'h0);
      end

      if (reset) begin
        if (redir_now) chk("req_on_redirect", 32'(imem_req), 32'h0);
        if (pend && !stale) chk("req_while_outstanding", 32'(imem_req), 32'h0);
        if (imem_req && imem_gnt) begin
          chk("fetch_addr", imem_addr, model_fetch_pc);
          e.ep = epoch;
          e.pc = model_fetch_pc;
          exp_q.push_back(e);
          pend = 1'b1;
          pend_cnt = dly - 1;
          pend_data = mem_word(imem_addr);
          model_fetch_pc = model_fetch_pc + 32'd4;
        end
      end
      if (redir_now) redir_prev = 1'b1;
    end

    repeat (3) @(negedge clk);
    chk("progress_min_deliveries", 32'(delivered >= 100), 32'h1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: compares every retired decode handshake against the predicted stream
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!reset) begin
        chk("reset_if_valid", 32'(if_valid), 32'h0);
        chk("reset_req", 32'(imem_req), 32'h0);
      end else if (if_valid && !stall) begin
        while (exp_q.size() > 0 && exp_q[0].ep < epoch) begin
          void'(exp_q.pop_front());
        end
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got if_pc %h, expected no delivery", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("if_pc", if_pc, e.pc);
          chk("if_instr", if_instr, mem_word(e.pc));
          chk("if_pc_plus4", if_pc_plus4, e.pc + 32'd4);
          delivered++;
        end
      end
    end
  end

endmodule
